cim_xbar_model: RTL and testbench

CIM_XBAR_MODEL -- requirements
Module: cim_xbar_model

---
 rtl/cim_pkg.sv | 16 +
 rtl/cim_col_acc.sv | 37 +++
 rtl/cim_xbar_model.sv | 109 ++++++++++
 tb/tb_cim_xbar_model.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared types and helpers for the compute-in-memory crossbar model.
package cim_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COMPUTE = 1'b1
  } cim_state_t;

  // Clamp an unsigned value to the largest number representable in width bits.
  function automatic logic [31:0] sat_to_width(input logic [31:0] value, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/cim_col_acc.sv
// One crossbar column: accumulates selected inputs row by row, then commits a saturated result.
module cim_col_acc
  import cim_pkg::*;
#(
  parameter int datatype_size = 8,
  parameter int acc_width     = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step,
  input  logic                     last,
  input  logic                     w_bit,
  input  logic [datatype_size-1:0] x,
  output logic [datatype_size-1:0] result
);

  logic [acc_width-1:0] acc;
  logic [acc_width-1:0] acc_sum;

  assign acc_sum = acc + (w_bit ? acc_width'(x) : '0);

  // The final row's contribution is folded into the committed value on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      result <= '0;
    end else if (step) begin
      if (last) begin
        acc    <= '0;
        result <= datatype_size'(sat_to_width(32'(acc_sum), datatype_size));
      end else begin
        acc <= acc_sum;
      end
    end
  end

endmodule

// File: rtl/cim_xbar_model.sv
// Binary-weight crossbar MVM responder: buffered inputs, one row per cycle, registered result reads.
module cim_xbar_model
  import cim_pkg::*;
#(
  parameter int xbar_size     = 128,
  parameter int datatype_size = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_we,
  input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
  input  logic [datatype_size-1:0]     i_wr_data,
  input  logic                         i_w_we,
  input  logic [$clog2(xbar_size)-1:0] i_w_row,
  input  logic [xbar_size-1:0]         i_w_data,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_done,
  input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
  output logic [datatype_size-1:0]     o_rd_data
);

  localparam int addr_width = $clog2(xbar_size);
  localparam int acc_width  = datatype_size + addr_width;
  localparam logic [addr_width-1:0] last_row = addr_width'(xbar_size - 1);

  cim_state_t state, state_next;
  logic [addr_width-1:0] row, row_next;
  logic done_next;

  logic [datatype_size-1:0] x_mem [xbar_size];
  logic [xbar_size-1:0]     w_mem [xbar_size];
  logic [datatype_size-1:0] col_result [xbar_size];

  logic step, last;
  logic [xbar_size-1:0]     cur_w;
  logic [datatype_size-1:0] cur_x;

  assign step   = (state == COMPUTE);
  assign last   = step && (row == last_row);
  assign o_busy = step;
  assign cur_w  = w_mem[row];
  assign cur_x  = x_mem[row];

  always_comb begin
    state_next = state;
    row_next   = row;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_next = COMPUTE;
          row_next   = '0;
        end
      end
      COMPUTE: begin
        if (row == last_row) begin
          state_next = IDLE;
          row_next   = '0;
          done_next  = 1'b1;
        end else begin
          row_next = row + addr_width'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      row    <= '0;
      o_done <= 1'b0;
    end else begin
      state  <= state_next;
      row    <= row_next;
      o_done <= done_next;
    end
  end

  // Buffers are not reset; writes land in IDLE only, so a same-cycle start sees them.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (i_we)   x_mem[i_wr_addr] <= i_wr_data;
      if (i_w_we) w_mem[i_w_row]   <= i_w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) o_rd_data <= '0;
    else     o_rd_data <= col_result[i_rd_addr];
  end

  for (genvar c = 0; c < xbar_size; c++) begin : g_col
    cim_col_acc #(
      .datatype_size(datatype_size),
      .acc_width    (acc_width)
    ) u_col (
      .clk   (clk),
      .rst   (rst),
      .step  (step),
      .last  (last),
      .w_bit (cur_w[c]),
      .x     (cur_x),
      .result(col_result[c])
    );
  end

endmodule

// File: tb/tb_cim_xbar_model.sv
// Directed bench for cim_xbar_model at 128x128, 8-bit elements.
module tb_cim_xbar_model;

  localparam int n  = 128;
  localparam int dw = 8;
  localparam int aw = $clog2(n);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_we;
  logic [aw-1:0] i_wr_addr;
  logic [dw-1:0] i_wr_data;
  logic          i_w_we;
  logic [aw-1:0] i_w_row;
  logic [n-1:0]  i_w_data;
  logic          i_start;
  logic          o_busy;
  logic          o_done;
  logic [aw-1:0] i_rd_addr;
  logic [dw-1:0] o_rd_data;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_res [n];

  cim_xbar_model #(.xbar_size(n), .datatype_size(dw)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_we     (i_we),
    .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data),
    .i_w_we   (i_w_we),
    .i_w_row  (i_w_row),
    .i_w_data (i_w_data),
    .i_start  (i_start),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_row(input int r, input int xv, input logic [n-1:0] wv);
    i_we      = 1'b1;
    i_wr_addr = aw'(r);
    i_wr_data = dw'(xv);
    i_w_we    = 1'b1;
    i_w_row   = aw'(r);
    i_w_data  = wv;
    tick();
    i_we   = 1'b0;
    i_w_we = 1'b0;
  endtask

  // Start an MVM and watch 140 cycles; optionally poke start and writes mid-compute.
  task automatic run_mvm(input string tag, input bit disturb);
    int first_done;
    int dones;
    first_done = -1;
    dones = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check({tag, " busy_after_start"}, int'(o_busy), 1);
    for (int i = 1; i <= 140; i++) begin
      if (disturb && i == 10) begin
        i_start   = 1'b1;
        i_we      = 1'b1;
        i_wr_addr = '0;
        i_wr_data = '0;
        i_w_we    = 1'b1;
        i_w_row   = '0;
        i_w_data  = '0;
      end
      tick();
      i_start = 1'b0;
      i_we    = 1'b0;
      i_w_we  = 1'b0;
      if (o_done) begin
        dones++;
        if (first_done < 0) first_done = i;
      end
    end
    check({tag, " done_latency"}, first_done, 128);
    check({tag, " done_pulses"}, dones, 1);
    check({tag, " busy_after_done"}, int'(o_busy), 0);
  endtask

  // Back-to-back reads; data must lag the address by exactly one edge.
  task automatic check_all(input string tag);
    for (int c = 0; c < n; c++) begin
      i_rd_addr = aw'(c);
      #1;
      if (c > 0) check($sformatf("%s hold%0d", tag, c), int'(o_rd_data), exp_res[c-1]);
      tick();
      check($sformatf("%s col%0d", tag, c), int'(o_rd_data), exp_res[c]);
    end
  endtask

  initial begin
    logic [n-1:0] wv;
    int dones;
    rst = 1'b1; i_we = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_w_we = 1'b0; i_w_row = '0; i_w_data = '0; i_start = 1'b0; i_rd_addr = 7'd5;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", int'(o_busy), 0);
    check("reset done", int'(o_done), 0);
    check("reset rd_data", int'(o_rd_data), 0);

    // Identity weights, x[r] = r
    for (int r = 0; r < n; r++) begin
      wv = '0;
      wv[r] = 1'b1;
      write_row(r, r, wv);
    end
    run_mvm("identity", 1'b0);
    for (int c = 0; c < n; c++) exp_res[c] = c;
    check_all("identity");

    // All weights 1, all x = 1
    for (int r = 0; r < n; r++) write_row(r, 1, '1);
    run_mvm("ones", 1'b0);
    for (int c = 0; c < n; c++) exp_res[c] = 128;
    check_all("ones");

    // Mid-compute start and writes are ignored, including for the following MVM
    run_mvm("busy_ignore", 1'b1);
    check_all("busy_ignore");
    run_mvm("busy_ignore_rerun", 1'b0);
    check_all("busy_ignore_rerun");

    // All weights 1, all x = 255 saturates
    for (int r = 0; r < n; r++) write_row(r, 255, '1);
    run_mvm("sat", 1'b0);
    for (int c = 0; c < n; c++) exp_res[c] = 255;
    check_all("sat");

    // Reset at row 50 aborts without commit
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check("abort busy_before_rst", int'(o_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", int'(o_busy), 0);
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (o_done) dones++;
    end
    check("abort no_done", dones, 0);
    check("abort still_idle", int'(o_busy), 0);
    for (int c = 0; c < n; c++) exp_res[c] = 0;
    check_all("abort");

    // Buffers survive reset, so a fresh start reproduces the saturated result
    run_mvm("after_rst", 1'b0);
    for (int c = 0; c < n; c++) exp_res[c] = 255;
    check_all("after_rst");

    // A write in the start cycle is used: 127 ones plus x[5] = 3
    for (int r = 0; r < n; r++) write_row(r, 1, '1);
    i_we      = 1'b1;
    i_wr_addr = 7'd5;
    i_wr_data = 8'd3;
    run_mvm("start_write", 1'b0);
    for (int c = 0; c < n; c++) exp_res[c] = 130;
    check_all("start_write");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
